// File: rtl/kernel_stream_driver.sv
// kernel_stream_driver: streams an NxN frame onto the kernel-RAM bus in 2-cycle holds,
// then sweeps the addresses again to capture one result byte per pixel.
module kernel_stream_driver #(
    parameter int N        = 8,
    parameter int BIT_SIZE = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_we,
    input  logic [BIT_SIZE:0] load_addr,
    input  logic [7:0]        load_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              kr_we,
    output logic [BIT_SIZE:0] kr_addr,
    output logic [7:0]        kr_data,
    input  logic [7:0]        kr_result,
    output logic              res_valid,
    output logic [BIT_SIZE:0] res_addr,
    output logic [7:0]        res_data
);
    localparam int NN = N * N;
    localparam int IW = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [BIT_SIZE:0] LAST = (BIT_SIZE + 1)'(NN - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t            st, st_n;
    logic              ph, ph_n;
    logic [BIT_SIZE:0] addr, addr_n;
    logic [7:0]        fb [NN];
    logic              load_ok, hold_end, run_n, cap_n;
    logic [7:0]        pix_n;

    assign load_ok  = st == IDLE && load_we && ({1'b0, load_addr} < (BIT_SIZE + 2)'(NN));
    assign hold_end = ph && addr == LAST;
    assign run_n    = st_n == WRITE || st_n == READ;
    assign cap_n    = st_n == READ && ph_n;
    // a host write landing on the same edge as start must be visible in the first pixel
    assign pix_n    = (load_ok && load_addr == addr_n) ? load_data : fb[addr_n[IW-1:0]];

    always_comb begin
        st_n   = st;
        ph_n   = ph;
        addr_n = addr;
        case (st)
            IDLE: if (start) begin
                st_n   = WRITE;
                ph_n   = 1'b0;
                addr_n = '0;
            end
            WRITE, READ: begin
                ph_n   = ~ph;
                addr_n = ph ? (hold_end ? '0 : addr + 1'b1) : addr;
                if (hold_end && st == WRITE) st_n = READ;
                if (hold_end && st == READ) st_n = DONE;
            end
            default: st_n = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (load_ok) fb[load_addr[IW-1:0]] <= load_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            ph        <= 1'b0;
            addr      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            kr_we     <= 1'b0;
            kr_addr   <= '0;
            kr_data   <= '0;
            res_valid <= 1'b0;
            res_addr  <= '0;
            res_data  <= '0;
        end else begin
            st        <= st_n;
            ph        <= ph_n;
            addr      <= addr_n;
            busy      <= run_n;
            done      <= st_n == DONE;
            kr_we     <= st_n == WRITE;
            kr_addr   <= run_n ? addr_n : '0;
            kr_data   <= st_n == WRITE ? pix_n : '0;
            res_valid <= cap_n;
            if (cap_n) begin
                res_addr <= addr_n;
                res_data <= kr_result;
            end
        end
    end
endmodule

// File: tb/tb_kernel_stream_driver.sv
// tb_kernel_stream_driver: random frames against a pixel-array model; a monitor pops
// expected bus writes, result captures and done times from scoreboard queues.
module tb_kernel_stream_driver;
    localparam int NN = 64;

    logic       clk = 0, rst_n = 0, load_we = 0, start = 0;
    logic [6:0] load_addr = '0;
    logic [7:0] load_data = '0;
    logic       busy, done, kr_we, res_valid;
    logic [6:0] kr_addr, res_addr;
    logic [7:0] kr_data, kr_result, res_data;
    logic       const_mode = 1;
    logic [7:0] salt = '0;
    logic [7:0] model [NN];
    logic [14:0] wq[$], rq[$];
    int dq[$];
    int cyc = 0, n_checks = 0, n_fail = 0, wcnt = 0;

    kernel_stream_driver #(.N(8), .BIT_SIZE(6)) dut (
        .clk(clk), .rst_n(rst_n), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .start(start), .busy(busy), .done(done),
        .kr_we(kr_we), .kr_addr(kr_addr), .kr_data(kr_data), .kr_result(kr_result),
        .res_valid(res_valid), .res_addr(res_addr), .res_data(res_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] res_f(input logic [6:0] a, input logic [7:0] s);
        return ({1'b0, a} * 8'd37) ^ s;
    endfunction

    assign kr_result = const_mode ? 8'hA5 : res_f(kr_addr, salt);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // monitor: every DUT event consumes the next expectation
    always @(negedge clk) begin
        if (!rst_n) begin
            wq.delete();
            rq.delete();
            dq.delete();
            wcnt = 0;
        end else begin
            if (kr_we) begin
                if (wq.size() == 0) check("wr_extra", {kr_addr, kr_data}, 32'hFFFF_FFFF);
                else begin
                    check("wr_bus", {kr_addr, kr_data}, wq[0]);
                    wcnt++;
                    if (wcnt == 2) begin
                        void'(wq.pop_front());
                        wcnt = 0;
                    end
                end
            end else wcnt = 0;
            if (busy && !kr_we) check("rd_bus_data", kr_data, 0);
            if (res_valid) begin
                if (rq.size() == 0) check("res_extra", {res_addr, res_data}, 32'hFFFF_FFFF);
                else check("res", {res_addr, res_data}, rq.pop_front());
            end
            if (done) begin
                if (dq.size() == 0) check("done_extra", cyc, 32'hFFFF_FFFF);
                else check("done_cycle", cyc, dq.pop_front());
                check("done_bus", {busy, kr_we, kr_addr, kr_data}, 0);
            end
        end
    end

    task automatic load(input logic [6:0] a, input logic [7:0] d);
        load_we = 1; load_addr = a; load_data = d;
        if (a < NN) model[a] = d;
        @(negedge clk);
        load_we = 0;
    endtask

    task automatic start_frame(input bit do_load, input logic [6:0] la, input logic [7:0] ld);
        int t0;
        start = 1; load_we = do_load; load_addr = la; load_data = ld;
        if (do_load && la < NN) model[la] = ld;
        @(posedge clk);
        #1;
        start = 0; load_we = 0;
        t0 = cyc;
        check("start_busy", {busy, kr_we}, 2'b11);
        for (int a = 0; a < NN; a++) begin
            wq.push_back({7'(a), model[a]});
            rq.push_back({7'(a), const_mode ? 8'hA5 : res_f(7'(a), salt)});
        end
        dq.push_back(t0 + 4 * NN);
    endtask

    task automatic wait_done(input bit poke);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
            if (poke && n == 10) begin
                start = 1; load_we = 1; load_addr = 7'd5; load_data = 8'h77;
            end else begin
                start = 0; load_we = 0;
            end
        end while (!done && n < 400);
        if (!done) check("done_timeout", n, 4 * NN + 1);
        check("queues_drained", wq.size() + rq.size(), 0);
    endtask

    initial begin
        #1;
        check("reset_bus", {busy, done, kr_we, kr_addr, kr_data}, 0);
        check("reset_res", {res_valid, res_addr, res_data}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int a = 0; a < NN; a++) load(7'(a), 8'(a));
        const_mode = 1;
        start_frame(0, '0, '0);
        wait_done(0);
        // start held through the DONE cycle must only be taken one cycle later
        start = 1;
        @(negedge clk);
        const_mode = 0;
        salt = 8'($urandom);
        start_frame(0, '0, '0);
        wait_done(1);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) load(7'($urandom_range(64, 127)), 8'($urandom));
        load(7'd64, 8'hEE);
        for (int a = 1; a < NN; a++) load(7'(a), 8'($urandom));
        start_frame(1, 7'd0, 8'h3C);
        wait_done(0);
        @(negedge clk);
        salt = 8'($urandom);
        start_frame(0, '0, '0);
        repeat (40) @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("midrst_bus", {busy, done, kr_we, kr_addr, kr_data}, 0);
        check("midrst_res", {res_valid, res_addr, res_data}, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        start_frame(0, '0, '0);
        wait_done(0);
        for (int f = 0; f < 2; f++) begin
            @(negedge clk);
            for (int i = 0; i < 12; i++) load(7'($urandom_range(0, 127)), 8'($urandom));
            salt = 8'($urandom);
            start_frame(0, '0, '0);
            wait_done(0);
        end
        repeat (5) @(negedge clk);
        check("no_pending_done", dq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/kernel_stream_driver.md
# kernel_stream_driver

Sequencer that feeds the 3x3 kernel RAM bank of the skeletonization datapath and collects its results. It holds an N×N 8-bit frame buffer loaded by the host, then runs two phases:
- a write phase that streams every pixel, with its linear address, onto the shared kernel-RAM bus;
- a read phase that sweeps the addresses again with write disabled and captures the kernel RAM result byte for each address.

It is the source/sink end of the bus consumed by the kernel RAM convolution units.

## Interface
- N, 8, image side length; frame is N*N pixels, row-major, address = row*N + col
- bitSize, 6, kernel-RAM address MSB index; bus address width is bitSize+1; N*N <= 2^(bitSize+1) is required
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- load_we  in  1  host write strobe into the frame buffer; honoured only in IDLE
- load_addr  in  bitSize+1  host frame-buffer address; writes with load_addr >= N*N are dropped
- load_data  in  8  host pixel value
- start  in  1  single-cycle request to run one frame; honoured only in IDLE
- busy  out  1  high from the cycle after start is accepted until the end of the READ state
- done  out  1  one-cycle pulse after the last result capture
- kr_we  out  1  kernel-RAM write enable
- kr_addr  out  bitSize+1  kernel-RAM pixel position / address
- kr_data  out  8  kernel-RAM pixel data
- kr_result  in  8  kernel-RAM primary output
- res_valid  out  1  result capture strobe
- res_addr  out  bitSize+1  address of the captured result
- res_data  out  8  captured result byte

## Operation
- States: IDLE, WRITE, READ, DONE.
- IDLE -> WRITE on start. WRITE -> READ after the last hold of address N*N-1. READ -> DONE after the last hold of address N*N-1. DONE -> IDLE unconditionally after 1 cycle.
- Hold rule: the kernel RAM acts only on alternate clock edges. Every bus value (kr_we, kr_addr, kr_data) is therefore held for exactly 2 consecutive cycles. A 1-bit phase register tracks the first and second cycle of each hold.
- WRITE:
  - kr_we = 1.
  - kr_addr steps 0, 1, …, N*N-1.
  - kr_data = frame_buffer[kr_addr].
  - Addresses are never skipped or repeated.
- READ:
  - kr_we = 0 and kr_data = 0.
  - kr_addr steps 0 … N*N-1 under the same 2-cycle hold.
  - On the second cycle of each hold: res_valid = 1, res_addr = kr_addr, res_data = kr_result sampled that cycle.
- DONE: done = 1 and the bus is idle (kr_we = 0, kr_addr = 0, kr_data = 0).
- Address counter: bitSize+1 bits, compared against N*N-1. It never wraps past N*N-1 and is cleared to 0 on each phase entry.
- Frame buffer:
  - N*N × 8 storage, not cleared by reset.
  - Host writes while busy are ignored.
  - A load_we and start in the same IDLE cycle perform the write first; the frame then uses the new value.
- start while busy or in DONE is ignored and not queued.
- Reset mid-operation: return to IDLE immediately. All outputs go to reset values, no done pulse is produced, and frame buffer contents are retained.

## Timing
- Reset values: busy = 0, done = 0, kr_we = 0, kr_addr = 0, kr_data = 0, res_valid = 0, res_addr = 0, res_data = 0.
- All outputs are registered.
- start sampled high at edge T: at T+1, busy = 1, kr_we = 1, kr_addr = 0, kr_data = frame_buffer[0].
- WRITE lasts 2*N*N cycles.
- READ lasts 2*N*N cycles. The first res_valid is at READ cycle 2; subsequent strobes follow every 2 cycles (N*N strobes total).
- done is asserted in the cycle after the final READ hold. busy is low in that same cycle.
- Start-to-done latency is 4*N*N + 1 cycles (257 for N = 8).
- A new start is accepted in the cycle after done.
- load_* is a single-cycle write with no read-back port.

## Test plan
- Reset mid-WRITE (rst_n low at cycle 40) -> all outputs 0 in the same cycle, state IDLE. A subsequent start runs a full frame with the original buffer contents.
- Load pixel = addr for all 64 addresses, start -> kr_addr 0..63, each held 2 cycles with kr_we = 1 and kr_data == kr_addr. Then 64 two-cycle holds with kr_we = 0. done at cycle 257 after start.
- Drive kr_result = 8'hA5 constant in READ -> exactly 64 res_valid strobes with res_data = 8'hA5 and res_addr 0..63 in order, each on the second cycle of its hold.
- Pulse start and load_we (addr 5, data 8'h77) at cycle 10 of a run -> no restart. Frame buffer[5] unchanged on the next run. done occurs once.
- load_we with load_addr = 64 (N = 8) -> no write. load_we and start in the same cycle at addr 0, data 8'h3C -> the first kr_data is 8'h3C.
